// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the CPU data port (D)
// and the I-cache refill port (I), round-robin on contention.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_bw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_hold,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_hold,
    output logic              mem_ce_n,
    output logic              mem_we_n,
    output logic              mem_oe_n,
    output logic              mem_bw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic       GNT_D    = 1'b0;
    localparam logic       GNT_I    = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              last_gnt;
    logic              gnt;
    logic              gnt_sel;
    logic              grant;
    logic              we_r;
    logic              bw_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              in_access;

    // Next state and grant selection; both requesting picks the port not served last.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_sel   = GNT_D;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    (d_req && i_req): begin
                        grant   = 1'b1;
                        gnt_sel = ~last_gnt;
                    end
                    (d_req && !i_req): begin
                        grant   = 1'b1;
                        gnt_sel = GNT_D;
                    end
                    (!d_req && i_req): begin
                        grant   = 1'b1;
                        gnt_sel = GNT_I;
                    end
                    default: grant = 1'b0;
                endcase
                if (grant) state_nxt = ACCESS;
            end
            ACCESS: if (cnt == 4'd0) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Latch the granted access, count down the latency, capture read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 4'd0;
            last_gnt <= GNT_I;
            gnt      <= GNT_D;
            we_r     <= 1'b0;
            bw_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            d_rdata  <= '0;
            i_rdata  <= '0;
        end else begin
            if (grant) begin
                gnt      <= gnt_sel;
                last_gnt <= gnt_sel;
                cnt      <= CNT_INIT;
                we_r     <= (gnt_sel == GNT_D) ? d_we : 1'b0;
                bw_r     <= (gnt_sel == GNT_D) ? d_bw : 1'b0;
                addr_r   <= (gnt_sel == GNT_D) ? d_addr : i_addr;
                wdata_r  <= (gnt_sel == GNT_D) ? d_wdata : '0;
            end
            if (in_access && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (in_access && cnt == 4'd0 && !we_r) begin
                if (gnt == GNT_D) d_rdata <= mem_rdata;
                else              i_rdata <= mem_rdata;
            end
        end
    end

    assign in_access = (state == ACCESS);
    assign mem_ce_n  = !in_access;
    assign mem_we_n  = !(in_access && we_r);
    assign mem_oe_n  = !(in_access && !we_r);
    assign mem_bw    = bw_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign d_ack     = (state == DONE) && (gnt == GNT_D);
    assign i_ack     = (state == DONE) && (gnt == GNT_I);
    assign d_hold    = d_req && !d_ack;
    assign i_hold    = i_req && !i_ack;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing one main-memory port between the CPU data port (port D) and the instruction-cache refill port (port I).
- Sits between MIPS_S/cache and a single ram instance.
- Sequences each access over a fixed memory latency, returns read data and a one-cycle ack, and drives per-port hold for CPU stall.
- Round-robin on contention, so neither port starves.

Parameters:
MEM_LATENCY, 2, cycles memory strobes stay asserted per access (legal range 1..15)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
d_req  in  1  port D access request; held with d_we/d_addr/d_wdata/d_bw stable until d_ack
d_we  in  1  port D write (1) / read (0)
d_bw  in  1  port D byte-write (1 = byte, 0 = word), passed to mem_bw
d_addr  in  ADDR_W  port D address
d_wdata  in  DATA_W  port D write data
d_rdata  out  DATA_W  port D read data, valid during d_ack
d_ack  out  1  one-cycle completion pulse, port D
d_hold  out  1  port D stall
i_req  in  1  port I refill request (read only)
i_addr  in  ADDR_W  port I address
i_rdata  out  DATA_W  port I read data, valid during i_ack
i_ack  out  1  one-cycle completion pulse, port I
i_hold  out  1  port I stall
mem_ce_n  out  1  memory chip enable, active low
mem_we_n  out  1  memory write enable, active low
mem_oe_n  out  1  memory output enable, active low
mem_bw  out  1  memory byte-write select
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid on last ACCESS cycle

Behaviour:
- Reset (async, reset_n=0): state IDLE; cnt=0; last_gnt=I; d_ack=i_ack=0; d_rdata=i_rdata=0; mem_ce_n=mem_we_n=mem_oe_n=1; mem_addr=mem_wdata=0; mem_bw=0.
- Reset mid-access aborts it: no ack is issued; strobes deassert immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port that is not last_gnt.
  - On grant: latch gnt, addr, we, wdata, bw into registers; set last_gnt=gnt; cnt=MEM_LATENCY-1; go to ACCESS.
- ACCESS:
  - Outputs: mem_ce_n=0; mem_addr/mem_wdata/mem_bw from latched registers.
  - Write: mem_we_n=0, mem_oe_n=1. Read: mem_we_n=1, mem_oe_n=0. Port I is always a read.
  - Each cycle cnt decrements. When cnt==0: on a read, capture mem_rdata into the granted port's rdata register at that edge; go to DONE.
- DONE:
  - Strobes deasserted.
  - Granted port's ack=1 for exactly this cycle.
  - rdata holds its value until that port's next completed read; writes leave rdata unchanged.
  - Next state is IDLE. No request is accepted in DONE.
- Latency: request first seen in IDLE at edge N -> ACCESS cycles N+1..N+MEM_LATENCY -> ack during cycle N+MEM_LATENCY+1.
- Uncontended access occupies MEM_LATENCY+2 cycles.
- Hold (combinational):
  - x_hold = x_req && !x_ack.
  - Hold asserts in the same cycle the request rises and drops in the ack cycle.
  - The losing port stays on hold through the winner's whole access and its own access.
- Request dropped before ack: latched access still completes and ack still pulses; requester ignores it. Req and input data are not re-sampled after grant.
- Simultaneous requests after reset: D wins (last_gnt=I).
- Back-to-back contention alternates D, I, D, I.
- A single port requesting continuously is granted every MEM_LATENCY+2 cycles regardless of last_gnt.
- d_ack and i_ack are never high together. Strobes are never active outside ACCESS.

Test Plan:
- Reset: reset_n=0 for 1 cycle with d_req=1 -> all strobes 1, acks 0, rdata 0. First cycle after release: d_hold=1, FSM enters ACCESS next edge.
- Single D read, MEM_LATENCY=2, d_addr=0x10010000, mem_rdata=0xDEADBEEF -> mem_oe_n=0 for exactly 2 cycles, d_ack one cycle later with d_rdata=0xDEADBEEF, d_hold low in ack cycle.
- D byte write, d_we=1, d_bw=1, d_wdata=0x000000A5 -> mem_we_n=0, mem_bw=1, mem_wdata=0xA5 for 2 cycles. d_ack pulses; d_rdata unchanged.
- Both requesting continuously from reset for 4 grants -> order D, I, D, I. Acks never overlap; each port's hold stays high until its own ack.
- Only i_req held high, i_addr=0x00400000 -> i_ack every 4 cycles (MEM_LATENCY=2); mem_we_n stays 1 throughout.
- reset_n pulsed low during the second ACCESS cycle -> strobes deassert asynchronously, no ack. Next request after release is served normally with D-first tie-break.
